// File: rtl/fir_pkg.sv
// Shared constants, coefficient table and state encoding for the 2x interpolating FIR.
package fir_pkg;

    localparam int unsigned DW    = 8;
    localparam int unsigned OW    = 16;
    localparam int unsigned CW    = 8;
    localparam int unsigned SHIFT = 7;
    localparam int unsigned NTAPS = 11;
    localparam int unsigned NPH0  = 6;
    localparam int unsigned NPH1  = 5;
    localparam int unsigned AW    = 20;
    localparam int unsigned KW    = 3;
    // One guard bit so the unity centre tap (+128 in Q1.7) is representable.
    localparam int unsigned HW    = CW + 1;
    localparam int unsigned PW    = DW + HW;

    typedef logic signed [HW-1:0] coeff_t;

    localparam coeff_t H [NTAPS] = '{
        coeff_t'(1),  coeff_t'(0),   coeff_t'(-9), coeff_t'(0), coeff_t'(72),
        coeff_t'(128),
        coeff_t'(72), coeff_t'(0),   coeff_t'(-9), coeff_t'(0), coeff_t'(1)
    };

    typedef enum logic [2:0] {
        IDLE,
        MAC_E,
        OUT_E,
        MAC_O,
        OUT_O
    } state_t;

    // Bounded coefficient lookup; out-of-range indices read as zero.
    function automatic coeff_t coef(input logic [3:0] idx);
        if (idx < 4'(NTAPS)) begin
            return H[idx];
        end
        return '0;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered signed multiply-accumulate with synchronous clear and enable.
module fir_mac
    import fir_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic signed [DW-1:0] i_x,
    input  coeff_t               i_c,
    output logic signed [AW-1:0] o_acc_nxt_c
);

    logic signed [PW-1:0] w_prod;
    logic signed [AW-1:0] r_acc;

    assign w_prod      = PW'(i_x) * PW'(i_c);
    assign o_acc_nxt_c = r_acc + AW'(w_prod);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_acc_nxt_c;
        end
    end

endmodule

// File: rtl/fir_interp2.sv
// 2x polyphase interpolating FIR: one input in, even then odd output out, one shared MAC.
module fir_interp2
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] x,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [OW-1:0] y,
    output logic          out_valid,
    input  logic          out_ready
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [KW-1:0]        r_k;
    logic [KW-1:0]        w_k_nxt;
    logic                 w_accept;
    logic                 w_clr;
    logic                 w_en;
    logic                 w_load_y;
    logic signed [DW-1:0] r_d [NPH0];
    logic signed [DW-1:0] w_tap;
    coeff_t               w_coef;
    logic signed [AW-1:0] w_acc_nxt;
    logic signed [AW-1:0] w_acc_sh;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [OW-1:0]        r_y;

    // Phase selects odd/even prototype tap: H[2k] or H[2k+1].
    assign w_coef   = coef({r_k, (r_state == MAC_O)});
    assign w_tap    = (r_k < KW'(NPH0)) ? r_d[r_k] : '0;
    assign w_acc_sh = w_acc_nxt >>> SHIFT;

    fir_mac u_mac (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_clr),
        .i_en        (w_en),
        .i_x         (w_tap),
        .i_c         (w_coef),
        .o_acc_nxt_c (w_acc_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_accept    = 1'b0;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        w_load_y    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept    = 1'b1;
                    w_clr       = 1'b1;
                    w_k_nxt     = '0;
                    w_state_nxt = MAC_E;
                end
            end
            MAC_E: begin
                w_en = 1'b1;
                if (r_k == KW'(NPH0 - 1)) begin
                    w_k_nxt     = '0;
                    w_load_y    = 1'b1;
                    w_state_nxt = OUT_E;
                end else begin
                    w_k_nxt = r_k + KW'(1);
                end
            end
            OUT_E: begin
                if (out_ready) begin
                    w_clr       = 1'b1;
                    w_k_nxt     = '0;
                    w_state_nxt = MAC_O;
                end
            end
            MAC_O: begin
                w_en = 1'b1;
                if (r_k == KW'(NPH1 - 1)) begin
                    w_k_nxt     = '0;
                    w_load_y    = 1'b1;
                    w_state_nxt = OUT_O;
                end else begin
                    w_k_nxt = r_k + KW'(1);
                end
            end
            OUT_O: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // y captures the final sum on the last MAC edge so it is valid as soon as OUT_* is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NPH0; i++) begin
                r_d[i] <= '0;
            end
            r_k         <= '0;
            r_y         <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_d[0] <= x;
                for (int unsigned i = 1; i < NPH0; i++) begin
                    r_d[i] <= r_d[i-1];
                end
            end
            if (w_load_y) begin
                r_y <= OW'(w_acc_sh);
            end
            r_k         <= w_k_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == OUT_E) || (w_state_nxt == OUT_O);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;

endmodule
